bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 104 ++++++++++
 tb/tb_bit_serializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register so that a
// continuous upstream stream produces a gap-free serial bit stream.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             a_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] hr_q, hr_d;
    logic             hr_full_q, hr_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             xfer;
    logic             sr_full;
    logic             at_last;
    logic             out_bit;
    logic [WIDTH-1:0] sr_shifted;

    // Ready depends only on registered state, never on din_valid.
    assign din_ready = ~hr_full_q;
    assign xfer      = din_valid & din_ready;
    assign sr_full   = (state_q == SHIFT);
    assign at_last   = sr_full & (cnt_q == LAST);

    assign out_bit    = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign sr_shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        hr_d      = hr_q;
        hr_full_d = hr_full_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    sr_d    = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    // Word boundary: refill from HR first, else straight from din.
                    cnt_d = '0;
                    if (hr_full_q) begin
                        sr_d      = hr_q;
                        hr_full_d = 1'b0;
                    end else if (xfer) begin
                        sr_d = din;
                    end else begin
                        sr_d    = '0;
                        state_d = IDLE;
                    end
                end else begin
                    sr_d  = sr_shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (xfer) begin
                        hr_d      = din;
                        hr_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            hr_q      <= '0;
            hr_full_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            hr_q      <= hr_d;
            hr_full_q <= hr_full_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bit_valid = sr_full;
    assign a_out     = sr_full & out_bit;
    assign last_bit  = at_last;
    assign busy      = sr_full | hr_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus
// and are compared each cycle against a queue-of-words reference model.
module tb_bit_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         rdy_m, a_m, bv_m, lb_m, busy_m;
    logic         rdy_l, a_l, bv_l, lb_l, busy_l;

    int total = 0;
    int bad   = 0;

    // Reference: words accepted and not yet fully sent; head is on the wire.
    logic [W-1:0] mq[$];
    int           mpos = 0;
    logic         acc = 1'b0;

    logic [W-1:0] cap_m = '0, cap_l = '0;
    int           ncap = 0, nlast = 0;
    logic         last_seen = 1'b0;
    logic [2:0]   det_hist = '0;
    int           det_n = 0, det_hits = 0, det_pos = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .a_out(a_m), .bit_valid(bv_m), .last_bit(lb_m), .busy(busy_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .a_out(a_l), .bit_valid(bv_l), .last_bit(lb_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_m"}, a_m, 1'b0);     chk({tag, "_a_l"}, a_l, 1'b0);
        chk({tag, "_bv_m"}, bv_m, 1'b0);   chk({tag, "_bv_l"}, bv_l, 1'b0);
        chk({tag, "_lb_m"}, lb_m, 1'b0);   chk({tag, "_lb_l"}, lb_l, 1'b0);
        chk({tag, "_busy_m"}, busy_m, 1'b0); chk({tag, "_busy_l"}, busy_l, 1'b0);
        chk({tag, "_rdy_m"}, rdy_m, 1'b1); chk({tag, "_rdy_l"}, rdy_l, 1'b1);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic step();
        logic e_bv, e_rdy, e_lb, e_am, e_al;
        @(negedge clk);
        e_bv  = (mq.size() != 0);
        e_rdy = (mq.size() < 2);
        e_lb  = e_bv && (mpos == W - 1);
        e_am  = 1'b0;
        e_al  = 1'b0;
        if (e_bv) begin
            e_am = mq[0][W-1-mpos];
            e_al = mq[0][mpos];
        end
        chk("rdy_m", rdy_m, e_rdy);   chk("rdy_l", rdy_l, e_rdy);
        chk("bv_m", bv_m, e_bv);      chk("bv_l", bv_l, e_bv);
        chk("lb_m", lb_m, e_lb);      chk("lb_l", lb_l, e_lb);
        chk("a_m", a_m, e_am);        chk("a_l", a_l, e_al);
        chk("busy_m", busy_m, e_bv);  chk("busy_l", busy_l, e_bv);
        last_seen = lb_m;
        if (lb_m) nlast++;
        if (bv_m) begin
            cap_m = {cap_m[W-2:0], a_m};
            cap_l = {a_l, cap_l[W-1:1]};
            ncap++;
            det_hist = {det_hist[1:0], a_m};
            det_n++;
            if (det_n >= 3 && det_hist == 3'b101) begin
                det_hits++;
                det_pos = det_n;
            end
        end
        @(posedge clk);
        acc = din_valid && (mq.size() < 2);
        if (mq.size() != 0) begin
            mpos++;
            if (mpos == W) begin
                void'(mq.pop_front());
                mpos = 0;
            end
        end
        if (acc) mq.push_back(din);
        #1;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [W-1:0] w);
        int guard;
        din = w;
        din_valid = 1'b1;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!acc && guard < 40);
        if (!acc) chk("send_timeout", 1'b0, 1'b1);
        din_valid = 1'b0;
    endtask

    task automatic clear_caps();
        cap_m = '0; cap_l = '0; ncap = 0; nlast = 0;
        det_hist = '0; det_n = 0; det_hits = 0; det_pos = 0;
    endtask

    initial begin
        #1;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Single word, first transfer on the first edge after release.
        clear_caps();
        send(8'hA5);
        idle(W + 1);
        chk32("a5_cap_m", 32'(cap_m), 32'hA5);
        chk32("a5_cap_l", 32'(cap_l), 32'hA5);
        chk32("a5_nbits", 32'(ncap), 32'd8);
        chk32("a5_nlast", 32'(nlast), 32'd1);

        // Back-to-back words with valid held high.
        clear_caps();
        send(8'hA5);
        send(8'h3C);
        idle(2 * W + 1);
        chk32("b2b_nbits", 32'(ncap), 32'd16);
        chk32("b2b_cap_m", 32'(cap_m), 32'h3C);
        chk32("b2b_nlast", 32'(nlast), 32'd2);

        // LSB-first ordering of a single set bit.
        clear_caps();
        send(8'h01);
        idle(W + 1);
        chk32("one_cap_l", 32'(cap_l), 32'h01);
        chk32("one_cap_m", 32'(cap_m), 32'h01);

        // Accept directly into the shifter on the last-bit cycle.
        clear_caps();
        send(8'h00);
        idle(W - 1);
        din = 8'hFF;
        din_valid = 1'b1;
        step();
        chk("lastacc_lb", last_seen, 1'b1);
        chk("lastacc_acc", acc, 1'b1);
        idle(W + 1);
        chk32("lastacc_nbits", 32'(ncap), 32'd16);
        chk32("lastacc_cap_m", 32'(cap_m), 32'hFF);

        // Asynchronous reset in the middle of a word.
        send(8'hA5);
        idle(3);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("midrst");
        mq.delete();
        mpos = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        idle(W + 4);

        // Drive the 101 detector model from the MSB-first stream.
        clear_caps();
        send(8'b0010_1000);
        idle(W + 1);
        chk32("det_hits", 32'(det_hits), 32'd1);
        chk32("det_pos", 32'(det_pos), 32'd5);

        // Random traffic obeying the hold-while-not-ready rule.
        acc = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (!din_valid || acc) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din = W'($urandom);
            end
            step();
        end
        idle(2 * W + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
